// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel-timing generator (counters, syncs, visible flag,
// line/frame strobes, frame counter).
// Optional: define FRAME_COUNTER_EN to build the 8-bit frame counter;
// when undefined frame_cnt is tied to zero.
module vga_sync_gen #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // level driven while a sync pulse is active
  localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  // counters are 10 bits wide; larger timings cannot be represented
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
    end
  endgenerate

  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap, v_wrap;

  // next-state counters; flags are derived from these so they line up
  // with the hpos/vpos registered on the same edge
  always_comb begin
    h_wrap = (hpos == H_LAST);
    v_wrap = h_wrap && (vpos == V_LAST);
    h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
    v_nxt  = vpos;
    if (h_wrap) v_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
  end

  // timing registers: advance on ena, hold otherwise, strobes self-clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos        <= 10'd0;
      vpos        <= 10'd0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      display_on  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ena) begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      hsync       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
      vsync       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
      display_on  <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef FRAME_COUNTER_EN
  // frame counter: steps together with the frame_start strobe it causes
  always_ff @(posedge clk) begin
    if (!rst_n)              frame_cnt <= 8'd0;
    else if (ena && v_wrap)  frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule
